// File: rtl/macc_dual_scheduler.sv
// Feeds operand beats to a dual MACC, accumulates NUM_PASSES results per output pair and queues the
// narrowed pairs in a first-word-fall-through FIFO. Define MACC_SCHED_SATURATE_EN to clamp instead of wrap.
//
// state | meaning
// IDLE  | no group being issued or accumulated, no beat in flight
// BUSY  | a group is partly issued or accumulated, or MACC results are outstanding
module macc_dual_scheduler #(
    parameter int  NUM_INPUTS   = 20,
    parameter int  NUM_PASSES   = 4,
    parameter int  MACC_LATENCY = 7,
    parameter int  FIFO_DEPTH   = 4,
    localparam int MACC_W       = 16 + $clog2(NUM_INPUTS),
    localparam int ACC_W        = MACC_W + $clog2(NUM_PASSES),
    localparam int DW           = 8 * NUM_INPUTS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            i_data_a,
    input  logic [DW-1:0]            i_data_b,
    input  logic [DW-1:0]            i_data_c,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [DW-1:0]            m_data_a,
    output logic [DW-1:0]            m_data_b,
    output logic [DW-1:0]            m_data_c,
    output logic                     m_valid,
    input  logic signed [MACC_W-1:0] m_res_a,
    input  logic signed [MACC_W-1:0] m_res_b,
    input  logic                     m_res_valid,
    output logic signed [15:0]       o_data_a,
    output logic signed [15:0]       o_data_b,
    output logic                     o_valid,
    input  logic                     i_ready
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int IP_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int CR_W = $clog2(FIFO_DEPTH + 1);
    localparam int FL_W = $clog2(MACC_LATENCY + 3);
    localparam logic [IP_W-1:0] LAST_PASS = IP_W'(NUM_PASSES - 1);
    localparam logic [CR_W-1:0] CR_FULL   = CR_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, BUSY} proc_t;

    proc_t                    state, state_nxt;
    logic [IP_W-1:0]          ip, ip_nxt, rp, rp_nxt;
    logic [CR_W-1:0]          cr, cr_nxt;
    logic [FL_W-1:0]          infl, infl_nxt;
    logic signed [ACC_W-1:0]  acc_a, acc_b, sum_a, sum_b, ext_a, ext_b;
    logic signed [15:0]       nar_a, nar_b;
    logic signed [15:0]       mem_a [FIFO_DEPTH];
    logic signed [15:0]       mem_b [FIFO_DEPTH];
    logic [PW:0]              wr_ptr, rd_ptr;
    logic                     accept, pop, start, res_ok, fifo_wr;

    // Credits reserve a FIFO slot per started group, so a result always has somewhere to go.
    assign o_ready  = (ip != '0) || (cr < CR_FULL);
    assign accept   = i_valid && o_ready;
    assign o_valid  = (wr_ptr != rd_ptr);
    assign pop      = o_valid && i_ready;
    assign o_data_a = mem_a[rd_ptr[PW-1:0]];
    assign o_data_b = mem_b[rd_ptr[PW-1:0]];
    assign ext_a    = ACC_W'(m_res_a);
    assign ext_b    = ACC_W'(m_res_b);

    always_comb begin
        state_nxt = state;
        ip_nxt    = ip;
        rp_nxt    = rp;
        cr_nxt    = cr;
        infl_nxt  = infl;
        start     = accept && (ip == '0);
        res_ok    = m_res_valid && (state == BUSY) && (infl != '0);
        fifo_wr   = res_ok && (rp == LAST_PASS);
        sum_a     = (rp == '0) ? ext_a : acc_a + ext_a;
        sum_b     = (rp == '0) ? ext_b : acc_b + ext_b;
        if (accept) ip_nxt = (ip == LAST_PASS) ? '0 : ip + 1'b1;
        if (res_ok) rp_nxt = (rp == LAST_PASS) ? '0 : rp + 1'b1;
        if (start && !pop)      cr_nxt = cr + 1'b1;
        else if (!start && pop) cr_nxt = cr - 1'b1;
        if (accept && !res_ok)      infl_nxt = infl + 1'b1;
        else if (!accept && res_ok) infl_nxt = infl - 1'b1;
        state_nxt = (ip_nxt == '0 && rp_nxt == '0 && infl_nxt == '0) ? IDLE : BUSY;
    end

    always_comb begin
        nar_a = sum_a[15:0];
        nar_b = sum_b[15:0];
`ifdef MACC_SCHED_SATURATE_EN
        if (sum_a > ACC_W'(32767))       nar_a = 16'sh7fff;
        else if (sum_a < -ACC_W'(32768)) nar_a = 16'sh8000;
        if (sum_b > ACC_W'(32767))       nar_b = 16'sh7fff;
        else if (sum_b < -ACC_W'(32768)) nar_b = 16'sh8000;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ip       <= '0;
            rp       <= '0;
            cr       <= '0;
            infl     <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            m_valid  <= 1'b0;
            m_data_a <= '0;
            m_data_b <= '0;
            m_data_c <= '0;
        end else begin
            state   <= state_nxt;
            ip      <= ip_nxt;
            rp      <= rp_nxt;
            cr      <= cr_nxt;
            infl    <= infl_nxt;
            m_valid <= accept;
            if (accept) begin
                m_data_a <= i_data_a;
                m_data_b <= i_data_b;
                m_data_c <= i_data_c;
            end
            if (res_ok) begin
                acc_a <= sum_a;
                acc_b <= sum_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem_a[wr_ptr[PW-1:0]] <= nar_a;
                mem_b[wr_ptr[PW-1:0]] <= nar_b;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_macc_dual_scheduler.sv
// Bench for macc_dual_scheduler: behavioural dual MACC (a.c, b.c dot products), group-sum scoreboard,
// table-driven single groups, hand-written corner sequences and a randomized run.
module tb_macc_dual_scheduler;
    localparam int N  = 20;
    localparam int P  = 4;
    localparam int L  = 7;
    localparam int D  = 4;
    localparam int MW = 16 + $clog2(N);
    localparam int DW = 8 * N;
`ifdef MACC_SCHED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] i_data_a = '0, i_data_b = '0, i_data_c = '0;
    logic i_valid = 1'b0, o_ready, m_valid, m_res_valid, o_valid, i_ready;
    logic rdy_main = 1'b1, rdy_rand = 1'b1, rand_on = 1'b0;
    logic [DW-1:0] m_data_a, m_data_b, m_data_c;
    logic signed [MW-1:0] m_res_a, m_res_b, inj_val = '0;
    logic inj_v = 1'b0;
    logic signed [15:0] o_data_a, o_data_b;

    int checks = 0, errors = 0, pop_cnt = 0, stall_cnt = 0;

    assign i_ready = rand_on ? rdy_rand : rdy_main;
    always #5 clk = ~clk;

    macc_dual_scheduler #(.NUM_INPUTS(N), .NUM_PASSES(P), .MACC_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_data_c(i_data_c),
        .i_valid(i_valid), .o_ready(o_ready),
        .m_data_a(m_data_a), .m_data_b(m_data_b), .m_data_c(m_data_c), .m_valid(m_valid),
        .m_res_a(m_res_a), .m_res_b(m_res_b), .m_res_valid(m_res_valid),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_valid(o_valid), .i_ready(i_ready)
    );

    function automatic longint dot(input logic [DW-1:0] x, input logic [DW-1:0] c);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(x[8*i +: 8])) * longint'($signed(c[8*i +: 8]));
        return s;
    endfunction

    function automatic int narrow(input longint s);
        logic signed [15:0] t;
        if (SAT && s > 32767)  return 32767;
        if (SAT && s < -32768) return -32768;
        t = s[15:0];
        return int'(t);
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Behavioural dual MACC: fixed L-cycle pipeline, cleared by the shared reset.
    logic   pv [L];
    longint pa [L], pb [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin pv[k] <= 1'b0; pa[k] <= 0; pb[k] <= 0; end
        end else begin
            pv[0] <= m_valid;
            pa[0] <= dot(m_data_a, m_data_c);
            pb[0] <= dot(m_data_b, m_data_c);
            for (int k = 1; k < L; k++) begin pv[k] <= pv[k-1]; pa[k] <= pa[k-1]; pb[k] <= pb[k-1]; end
        end
    end
    assign m_res_valid = pv[L-1] | inj_v;
    assign m_res_a     = inj_v ? inj_val : MW'(pa[L-1]);
    assign m_res_b     = inj_v ? inj_val : MW'(pb[L-1]);

    // Scoreboard: group sums computed from accepted beats, compared at each pop.
    int           exp_a[$], exp_b[$];
    int           beat_idx = 0, open_grp = 0;
    longint       gsum_a = 0, gsum_b = 0;
    logic         last_hs = 1'b0, hs, pp;
    logic [DW-1:0] last_a, last_b, last_c;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete(); exp_b.delete();
            beat_idx = 0; open_grp = 0; gsum_a = 0; gsum_b = 0; last_hs = 1'b0;
        end else begin
            hs = i_valid && o_ready;
            pp = o_valid && i_ready;
            if (i_valid && !o_ready) stall_cnt++;
            chk("o_ready", o_ready, !(beat_idx == 0 && open_grp >= D));
            chk("m_valid", m_valid, last_hs);
            if (last_hs)
                chk("m_data", (m_data_a == last_a && m_data_b == last_b && m_data_c == last_c), 1);
            if (pp) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got a=%0d b=%0d, expected none", o_data_a, o_data_b);
                end else begin
                    chk("sb_o_data_a", o_data_a, exp_a.pop_front());
                    chk("sb_o_data_b", o_data_b, exp_b.pop_front());
                end
                pop_cnt++;
                open_grp--;
            end
            if (hs) begin
                if (beat_idx == 0) open_grp++;
                gsum_a += dot(i_data_a, i_data_c);
                gsum_b += dot(i_data_b, i_data_c);
                beat_idx++;
                if (beat_idx == P) begin
                    exp_a.push_back(narrow(gsum_a));
                    exp_b.push_back(narrow(gsum_b));
                    beat_idx = 0; gsum_a = 0; gsum_b = 0;
                end
            end
            last_hs = hs; last_a = i_data_a; last_b = i_data_b; last_c = i_data_c;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        int n = 0;
        i_data_a = a; i_data_b = b; i_data_c = c; i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && n < 300) begin @(negedge clk); n++; end
        if (!o_ready) fail_now("send_beat");
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic send_group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int k = 0; k < P; k++) send_beat(fill(a), fill(b), fill(c));
    endtask

    task automatic wait_out(output int n);
        n = 1;
        @(negedge clk);
        while (!o_valid && n < 60) begin @(negedge clk); n++; end
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pop_cnt < target && n < 600) begin @(negedge clk); n++; end
        if (pop_cnt < target) fail_now(name);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            rdy_rand = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [7:0] a, b, c; int ea, eb; } vec_t;
    vec_t tbl [6];

    initial begin
        int lat, base, seen;
        logic [DW-1:0] ra, rb, rc;
        tbl[0] = '{a:8'd1,   b:8'd2,   c:8'd3,   ea:240,                   eb:480};
        tbl[1] = '{a:8'd127, b:8'd0,   c:8'd127, ea:SAT ? 32767 : -20400,  eb:0};
        tbl[2] = '{a:8'hFF,  b:8'd5,   c:8'd2,   ea:-160,                  eb:800};
        tbl[3] = '{a:8'h80,  b:8'h80,  c:8'd127, ea:SAT ? -32768 : 10240,  eb:SAT ? -32768 : 10240};
        tbl[4] = '{a:8'h80,  b:8'd0,   c:8'h80,  ea:SAT ? 32767 : 0,       eb:0};
        tbl[5] = '{a:8'd10,  b:8'hF6,  c:8'd10,  ea:8000,                  eb:-8000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data_a", o_data_a, 0);
        chk("rst_o_data_b", o_data_b, 0);
        chk("rst_o_ready", o_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", (m_data_a == '0 && m_data_b == '0 && m_data_c == '0), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single groups: value and last-beat-to-o_valid latency
        foreach (tbl[i]) begin
            send_group(tbl[i].a, tbl[i].b, tbl[i].c);
            wait_out(lat);
            chk($sformatf("tbl%0d_latency", i), lat, 1 + L + 1);
            chk($sformatf("tbl%0d_o_data_a", i), o_data_a, tbl[i].ea);
            chk($sformatf("tbl%0d_o_data_b", i), o_data_b, tbl[i].eb);
            @(posedge clk); #1;
        end

        // Backpressure: four groups fill the FIFO, fifth group blocked, then drain with pop+start overlap
        base = pop_cnt;
        rdy_main = 1'b0;
        for (int g = 0; g < D; g++) send_group(8'(g + 1), 8'd2, 8'd1);
        i_data_a = fill(8'd9); i_data_b = fill(8'd3); i_data_c = fill(8'd1); i_valid = 1'b1;
        @(negedge clk);
        chk("bp_o_ready_low", o_ready, 0);
        repeat (20) @(negedge clk);
        chk("bp_still_blocked", o_ready, 0);
        chk("bp_fifo_full_valid", o_valid, 1);
        chk("bp_no_pop", pop_cnt - base, 0);
        @(posedge clk); #1;
        rdy_main = 1'b1;
        send_group(8'd9, 8'd3, 8'd1);
        wait_pops(base + D + 1, "bp_drain");
        chk("bp_pops", pop_cnt - base, D + 1);

        // Mid-group reset discards partial accumulation
        send_beat(fill(8'd50), fill(8'd50), fill(8'd50));
        send_beat(fill(8'd50), fill(8'd50), fill(8'd50));
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin @(negedge clk); if (o_valid) seen = 1; end
        chk("rst_mid_no_output", seen, 0);
        @(posedge clk); #1;
        base = pop_cnt;
        send_group(8'd1, 8'd2, 8'd3);
        wait_out(lat);
        chk("rst_mid_o_data_a", o_data_a, 240);
        chk("rst_mid_o_data_b", o_data_b, 480);
        @(posedge clk); #1;
        repeat (12) @(posedge clk); #1;
        chk("rst_mid_single_output", pop_cnt - base, 1);

        // Spurious MACC result with nothing in flight is ignored
        inj_val = MW'(1000); inj_v = 1'b1;
        @(posedge clk); #1;
        inj_v = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("spurious_no_output", o_valid, 0);
        send_group(8'd1, 8'd2, 8'd3);
        wait_out(lat);
        chk("spurious_o_data_a", o_data_a, 240);
        chk("spurious_o_data_b", o_data_b, 480);
        @(posedge clk); #1;

        // Back-to-back groups with i_ready high: never stalls
        base = pop_cnt;
        stall_cnt = 0;
        for (int g = 0; g < 8; g++) send_group(8'(g + 3), 8'(8'hF0 + g), 8'(g + 1));
        chk("b2b_no_stall", stall_cnt, 0);
        wait_pops(base + 8, "b2b_drain");
        chk("b2b_pops", pop_cnt - base, 8);

        // Randomized beats and backpressure against the scoreboard
        base = pop_cnt;
        rand_on = 1'b1;
        for (int k = 0; k < 200; k++) begin
            for (int j = 0; j < N; j++) begin
                ra[8*j +: 8] = 8'($urandom); rb[8*j +: 8] = 8'($urandom); rc[8*j +: 8] = 8'($urandom);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(ra, rb, rc);
        end
        rand_on = 1'b0;
        wait_pops(base + 50, "rand_drain");
        chk("rand_pops", pop_cnt - base, 50);
        repeat (5) @(posedge clk); #1;
        chk("end_queue_empty", exp_a.size(), 0);
        chk("end_o_valid", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
